ahb_input_slave: RTL and testbench

- AHB-Lite slave sitting directly upstream of the GPU's triangle input path (clip_split).
- Host writes packed triangle words to a DATA register.
- Words are buffered in a FIFO and presented as ahb_buffer / ahb_data_available; the consumer pops with ahb_user_read_buffer.
- Provides STATUS/CONTROL registers and back-pressures the bus with wait states when full.

---
 rtl/ahb_input_slave_pkg.sv | 35 +++
 rtl/ahb_input_slave_sync_fifo.sv | 64 ++++++
 rtl/ahb_input_slave.sv | 150 +++++++++++++++
 tb/tb_ahb_input_slave.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_input_slave_pkg.sv
// Shared constants for the AHB triangle-input slave: register map, HTRANS codes, STATUS bits.
// Latency: n/a (definitions only).
// Backpressure: n/a. Optional error responses are enabled by defining AHB_INPUT_ERR_RESP_EN.
package ahb_input_slave_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 16;

    // Byte offsets of the programmer-visible registers
    localparam logic [3:0] DATA_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CTRL_OFS   = 4'h8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // STATUS layout; the occupancy count sits in the low bits
    localparam int STATUS_FULL_BIT  = 16;
    localparam int STATUS_EMPTY_BIT = 17;
    localparam int STATUS_OVF_BIT   = 18;

    // CONTROL layout
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    function automatic logic is_mapped(input logic [3:0] ofs);
        return (ofs == DATA_OFS) || (ofs == STATUS_OFS) || (ofs == CTRL_OFS);
    endfunction

endpackage

// File: rtl/ahb_input_slave_sync_fifo.sv
// Generic synchronous FIFO with push, pop, flush, head word and occupancy count.
// Latency: a pushed word appears on o_head the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens the same cycle; pop while empty is ignored.
module ahb_input_slave_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Head reads as zero when empty so consumers never see stale storage
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers and count; flush beats any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (n_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ahb_input_slave.sv
// AHB-Lite slave buffering host-written triangle words for clip_split; STATUS/CONTROL registers.
// Latency: zero-wait reads/writes; a pushed word is visible on ahb_buffer one cycle after the push edge.
// Backpressure: DATA writes to a full FIFO hold hreadyout low until a pop frees a slot (AHB_INPUT_ERR_RESP_EN adds ERROR responses).
module ahb_input_slave
    import ahb_input_slave_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [3:0]  haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic [31:0] ahb_buffer,
    output logic        ahb_data_available,
    input  logic        ahb_user_read_buffer
);
    logic             r_dp_vld;
    logic             r_dp_write;
    logic [3:0]       r_dp_addr;
    logic             r_ovf;

    logic             w_addr_acc;
    logic             w_bad;
    logic             w_wr_data;
    logic             w_wr_ctrl;
    logic             w_rd_status;
    logic             w_pop_ok;
    logic             w_underflow;
    logic             w_stall;
    logic             w_push;
    logic             w_flush;
    logic             w_clr_ovf;
    logic [31:0]      w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic [31:0]      w_status;
    logic             w_unused_inputs;

    // Only NONSEQ/SEQ open a data phase; IDLE/BUSY are ignored
    assign w_addr_acc = hsel & hready & htrans[1];

    // Capture the address phase whenever the bus advances
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_dp_vld   <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
        end else if (hready) begin
            r_dp_vld   <= w_addr_acc;
            r_dp_write <= hwrite;
            r_dp_addr  <= haddr;
        end
    end

`ifdef AHB_INPUT_ERR_RESP_EN
    logic r_dp_bad_size;
    logic r_err_st;

    // Bad accesses: unmapped offset, STATUS write, or non-word size
    assign w_bad = r_dp_vld & (~is_mapped(r_dp_addr)
                               | (r_dp_write & (r_dp_addr == STATUS_OFS))
                               | r_dp_bad_size);

    // Size check latched with the address; r_err_st marks the second ERROR cycle
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_dp_bad_size <= 1'b0;
            r_err_st      <= 1'b0;
        end else begin
            if (hready) r_dp_bad_size <= (hsize != HSIZE_WORD);
            r_err_st <= w_bad & ~r_err_st;
        end
    end

    assign hreadyout       = w_bad ? r_err_st : ~w_stall;
    assign hresp           = w_bad;
    assign w_unused_inputs = htrans[0];
`else
    assign w_bad           = 1'b0;
    assign hreadyout       = ~w_stall;
    assign hresp           = 1'b0;
    assign w_unused_inputs = ^{htrans[0], hsize};
`endif

    assign w_wr_data   = r_dp_vld &  r_dp_write & ~w_bad & (r_dp_addr == DATA_OFS);
    assign w_wr_ctrl   = r_dp_vld &  r_dp_write & ~w_bad & (r_dp_addr == CTRL_OFS);
    assign w_rd_status = r_dp_vld & ~r_dp_write & ~w_bad & (r_dp_addr == STATUS_OFS);

    assign w_pop_ok    = ahb_user_read_buffer & ~w_empty;
    assign w_underflow = ahb_user_read_buffer &  w_empty;

    // A full FIFO stalls the write unless the consumer frees a slot this very cycle
    assign w_stall   = w_wr_data & w_full & ~w_pop_ok;
    assign w_push    = w_wr_data & ~w_stall;
    assign w_flush   = w_wr_ctrl & hwdata[CTRL_FLUSH_BIT];
    assign w_clr_ovf = w_wr_ctrl & hwdata[CTRL_CLR_OVF_BIT];

    ahb_input_slave_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_push     (w_push),
        .i_push_dat (hwdata),
        .i_pop      (ahb_user_read_buffer),
        .i_flush    (w_flush),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Sticky pop-while-empty flag; a fresh underflow outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_ovf <= 1'b0;
        end else if (w_underflow) begin
            r_ovf <= 1'b1;
        end else if (w_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Assemble the STATUS word
    always_comb begin
        w_status                   = '0;
        w_status[CNT_W-1:0]        = w_count;
        w_status[STATUS_FULL_BIT]  = w_full;
        w_status[STATUS_EMPTY_BIT] = w_empty;
        w_status[STATUS_OVF_BIT]   = r_ovf;
    end

    // DATA and CONTROL read back as zero, as do unmapped offsets
    assign hrdata             = w_rd_status ? w_status : '0;
    assign ahb_buffer         = w_head;
    assign ahb_data_available = ~w_empty;

endmodule

// File: tb/tb_ahb_input_slave.sv
// Randomised bench for ahb_input_slave: a queue-based reference model predicts every cycle's outputs.
// Latency: predictions are queued at drive time and compared by an independent negedge monitor.
// Backpressure: the driver holds address/data phases while the model predicts a wait state.
module tb_ahb_input_slave;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        hsel = 1'b0;
    logic [3:0]  haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = '0;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] ahb_buffer;
    logic        ahb_data_available;
    logic        ahb_user_read_buffer = 1'b0;

    // Single-slave bus: global HREADY is this slave's HREADYOUT
    assign hready = hreadyout;

    always #5 clk = ~clk;

    ahb_input_slave dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .hsel                 (hsel),
        .haddr                (haddr),
        .htrans               (htrans),
        .hwrite               (hwrite),
        .hsize                (hsize),
        .hwdata               (hwdata),
        .hready               (hready),
        .hreadyout            (hreadyout),
        .hresp                (hresp),
        .hrdata               (hrdata),
        .ahb_buffer           (ahb_buffer),
        .ahb_data_available   (ahb_data_available),
        .ahb_user_read_buffer (ahb_user_read_buffer)
    );

    typedef struct {
        logic        idle;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] dat;
        logic [2:0]  size;
    } xfer_t;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic        avail;
        logic [31:0] rdata;
        logic [31:0] head;
    } exp_t;

    exp_t        expq[$];
    xfer_t       txq[$];
    logic [31:0] mq[$];
    exp_t        mon_e;

    // Reference model state
    logic        m_ovf = 1'b0;
    logic        m_dp_vld = 1'b0;
    logic        m_dp_wr = 1'b0;
    logic [3:0]  m_dp_addr = '0;
    logic [31:0] m_dp_dat = '0;
`ifdef AHB_INPUT_ERR_RESP_EN
    logic        m_dp_bad_size = 1'b0;
    logic        m_err_st = 1'b0;
`endif
    int          stall_run = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compare whatever the model predicted for this cycle
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("hreadyout", 32'(hreadyout), 32'(mon_e.rdy));
            chk("hresp", 32'(hresp), 32'(mon_e.resp));
            chk("hrdata", hrdata, mon_e.rdata);
            chk("ahb_data_available", 32'(ahb_data_available), 32'(mon_e.avail));
            chk("ahb_buffer", ahb_buffer, mon_e.head);
            cyc++;
        end
    end

    function automatic xfer_t mk(input logic idle, input logic wr, input logic [3:0] addr,
                                 input logic [31:0] dat, input logic [2:0] size);
        xfer_t x;
        x.idle = idle; x.wr = wr; x.addr = addr; x.dat = dat; x.size = size;
        return x;
    endfunction

    task automatic wr(input logic [3:0] addr, input logic [31:0] dat);
        txq.push_back(mk(1'b0, 1'b1, addr, dat, 3'b010));
    endtask

    task automatic rd(input logic [3:0] addr);
        txq.push_back(mk(1'b0, 1'b0, addr, 32'h0, 3'b010));
    endtask

    // One bus cycle: drive inputs, predict outputs from the model, then advance the model
    task automatic step(input logic a_vld, input xfer_t a, input logic pop, input logic rst,
                        output logic rdy);
        exp_t        e;
        logic        bad, wr_data, wr_ctrl, rd_stat, stall, under, popok;
        logic [31:0] st;
        @(posedge clk);
        #1;
        n_rst                = rst;
        hsel                 = 1'b1;
        htrans               = a_vld ? 2'b10 : 2'b00;
        haddr                = a.addr;
        hwrite               = a.wr;
        hsize                = a.size;
        hwdata               = m_dp_dat;
        ahb_user_read_buffer = pop;

        bad = 1'b0;
`ifdef AHB_INPUT_ERR_RESP_EN
        bad = m_dp_vld && (!(m_dp_addr inside {4'h0, 4'h4, 4'h8})
                           || (m_dp_wr && m_dp_addr == 4'h4) || m_dp_bad_size);
`endif
        wr_data = m_dp_vld && m_dp_wr && !bad && (m_dp_addr == 4'h0);
        wr_ctrl = m_dp_vld && m_dp_wr && !bad && (m_dp_addr == 4'h8);
        rd_stat = m_dp_vld && !m_dp_wr && !bad && (m_dp_addr == 4'h4);
        popok   = pop && (mq.size() > 0);
        under   = pop && (mq.size() == 0);
        stall   = wr_data && (mq.size() == DEPTH) && !popok;

        st     = 32'(mq.size());
        st[16] = (mq.size() == DEPTH);
        st[17] = (mq.size() == 0);
        st[18] = m_ovf;

        e.rdy  = !stall;
        e.resp = 1'b0;
`ifdef AHB_INPUT_ERR_RESP_EN
        if (bad) begin
            e.rdy  = m_err_st;
            e.resp = 1'b1;
        end
`endif
        e.rdata = rd_stat ? st : 32'h0;
        e.avail = (mq.size() > 0);
        e.head  = (mq.size() > 0) ? mq[0] : 32'h0;
        expq.push_back(e);
        rdy = e.rdy;

        if (rst) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_dp_vld  = 1'b0;
            stall_run = 0;
`ifdef AHB_INPUT_ERR_RESP_EN
            m_err_st  = 1'b0;
`endif
        end else begin
            if (wr_ctrl && m_dp_dat[0]) begin
                mq.delete();
            end else begin
                if (popok) void'(mq.pop_front());
                if (wr_data && !stall) mq.push_back(m_dp_dat);
            end
            if (wr_ctrl && m_dp_dat[1]) m_ovf = 1'b0;
            if (under) m_ovf = 1'b1;
`ifdef AHB_INPUT_ERR_RESP_EN
            m_err_st = bad && !m_err_st;
`endif
            if (e.rdy) begin
                m_dp_vld  = a_vld;
                m_dp_wr   = a.wr;
                m_dp_addr = a.addr;
                m_dp_dat  = a.dat;
`ifdef AHB_INPUT_ERR_RESP_EN
                m_dp_bad_size = (a.size != 3'b010);
`endif
            end
            stall_run = stall ? stall_run + 1 : 0;
        end
    endtask

    // Play the transfer queue. mode: 0 no pop, 1 pop always, 2 random pop,
    // 3 pop after 3 stall cycles, 4 reset after 3 stall cycles, 5 pop during CONTROL data phase
    task automatic run(input int mode);
        int    guard;
        logic  rdy, pop, rst, av;
        xfer_t a;
        guard = 0;
        while ((txq.size() > 0 || m_dp_vld) && guard < 4000) begin
            av  = (txq.size() > 0);
            a   = av ? txq[0] : mk(1'b1, 1'b0, 4'h0, 32'h0, 3'b010);
            pop = 1'b0;
            rst = 1'b0;
            case (mode)
                1: pop = 1'b1;
                2: pop = ($urandom_range(0, 1) == 1);
                3: pop = (stall_run >= 3);
                4: rst = (stall_run >= 3);
                5: pop = m_dp_vld && m_dp_wr && (m_dp_addr == 4'h8);
                default: pop = 1'b0;
            endcase
            step(av && !a.idle, a, pop, rst, rdy);
            if (rst) txq.delete();
            else if (av && rdy) void'(txq.pop_front());
            guard++;
        end
        if (guard >= 4000) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_bound mode=%0d got=%0d cycles want<4000", mode, guard);
        end
    endtask

    task automatic idle(input int n, input logic pop);
        logic rdy;
        for (int i = 0; i < n; i++) step(1'b0, mk(1'b1, 1'b0, 4'h0, 32'h0, 3'b010), pop, 1'b0, rdy);
    endtask

    initial begin
        logic rdy;
        // Reset
        for (int i = 0; i < 3; i++) step(1'b0, mk(1'b1, 1'b0, 4'h0, 32'h0, 3'b010), 1'b0, 1'b1, rdy);

        // Single push then STATUS
        wr(4'h0, 32'hDEADBEEF); rd(4'h4); run(0); idle(2, 1'b0);
        wr(4'h8, 32'h1); run(0); idle(1, 1'b0);

        // Fill, 17th write stalls until a late pop
        for (int i = 0; i < 17; i++) wr(4'h0, 32'h1000 + 32'(i));
        run(3);
        rd(4'h4); run(0);

        // Flush with a same-cycle pop
        wr(4'h8, 32'h1); run(0);
        for (int i = 0; i < 5; i++) wr(4'h0, $urandom);
        wr(4'h8, 32'h1); run(5);
        rd(4'h4); run(0); idle(1, 1'b0);

        // Streaming with a pop every cycle
        for (int i = 0; i < 20; i++) wr(4'h0, $urandom);
        run(1); idle(2, 1'b1);

        // Underflow sticky and its clear
        rd(4'h4); wr(4'h8, 32'h2); rd(4'h4); run(0);

        // Unmapped / illegal accesses
        wr(4'h0, 32'hAAAA5555); wr(4'hC, 32'h1234); rd(4'hC); wr(4'h4, 32'hFFFFFFFF);
        rd(4'h8); rd(4'h0); rd(4'h2);
        txq.push_back(mk(1'b0, 1'b1, 4'h0, 32'h5A5A0001, 3'b000));
        rd(4'h4); run(0);
        wr(4'h8, 32'h3); run(0);

        // Random mix of DATA writes, STATUS/DATA reads, idle gaps, random pops
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: txq.push_back(mk(1'b0, 1'b1, 4'h0, $urandom,
                                          ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010));
                3:       rd(4'h4);
                4:       rd(4'h0);
                default: txq.push_back(mk(1'b1, 1'b0, 4'h0, 32'h0, 3'b010));
            endcase
        end
        run(2);
        rd(4'h4); run(0);

        // Reset while a write is stalled
        wr(4'h8, 32'h3); run(0);
        for (int i = 0; i < 17; i++) wr(4'h0, 32'h2000 + 32'(i));
        run(4);
        idle(3, 1'b0);
        rd(4'h4); run(0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending want=0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
